io_port_responder: RTL

IO_PORT_RESPONDER -- requirements
Module: io_port_responder

---
 rtl/io_port_responder.sv | 79 +++++++
 1 files changed

// File: rtl/io_port_responder.sv
// io_port_responder: CPU I/O port decode with LED/7-seg latches, synchronized inputs, button and timer interrupts.
module io_port_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int TMR_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       io_strb,
    output logic [7:0] in_port,
    input  logic [7:0] switches,
    input  logic [3:0] buttons,
    output logic [7:0] leds,
    output logic [7:0] sseg_val,
    output logic       interrupt
);
    typedef enum logic {IDLE, RUN} tmr_state_t;
    tmr_state_t state, state_next;
    logic [SYNC_STAGES-1:0][7:0] sw_ff;
    logic [SYNC_STAGES-1:0][3:0] btn_ff;
    logic [7:0] sw_sync;
    logic [3:0] btn_sync, btn_prev, btn_rise, btn_pend, btn_pend_next;
    logic [15:0] reload, count16;
    logic [4:0] ctrl, clr;
    logic [TMR_W-1:0] count, count_next;
    logic tmr_pend, tmr_pend_next, tmr_set, wr_ctrl;
    assign sw_sync  = sw_ff[SYNC_STAGES-1];
    assign btn_sync = btn_ff[SYNC_STAGES-1];
    assign count16  = 16'(count);
    always_comb begin
        wr_ctrl       = io_strb && port_id == 8'h92;
        clr           = (io_strb && port_id == 8'h93) ? out_port[4:0] : 5'b0;
        btn_rise      = btn_sync & ~btn_prev;
        state_next    = wr_ctrl ? (out_port[0] ? RUN : IDLE) : state;
        tmr_set       = state == RUN && state_next == RUN && count == '0;
        count_next    = (state == IDLE && state_next == RUN) ? TMR_W'(reload) :
                        (state == RUN && state_next == RUN) ?
                            (count == '0 ? TMR_W'(reload) : count - TMR_W'(1)) : count;
        btn_pend_next = (btn_pend & ~clr[3:0]) | btn_rise;
        tmr_pend_next = (tmr_pend & ~clr[4]) | tmr_set;
        in_port       = port_id == 8'h20 ? sw_sync :
                        port_id == 8'h21 ? {3'b0, tmr_pend, btn_pend} :
                        port_id == 8'h22 ? count16[7:0] :
                        port_id == 8'h23 ? count16[15:8] :
                        port_id == 8'h24 ? {3'b0, ctrl} : 8'h00;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_ff     <= '0;
            btn_ff    <= '0;
            btn_prev  <= '0;
            state     <= IDLE;
            count     <= '0;
            btn_pend  <= '0;
            tmr_pend  <= 1'b0;
            interrupt <= 1'b0;
            leds      <= '0;
            sseg_val  <= '0;
            reload    <= '0;
            ctrl      <= '0;
        end else begin
            sw_ff     <= {sw_ff[SYNC_STAGES-2:0], switches};
            btn_ff    <= {btn_ff[SYNC_STAGES-2:0], buttons};
            btn_prev  <= btn_sync;
            state     <= state_next;
            count     <= count_next;
            btn_pend  <= btn_pend_next;
            tmr_pend  <= tmr_pend_next;
            // interrupt tracks the registered pend/mask state, so it lags them by one cycle
            interrupt <= |(btn_pend & ctrl[4:1]) | tmr_pend;
            if (io_strb && port_id == 8'h40) leds <= out_port;
            if (io_strb && port_id == 8'h81) sseg_val <= out_port;
            if (io_strb && port_id == 8'h90) reload[7:0] <= out_port;
            if (io_strb && port_id == 8'h91) reload[15:8] <= out_port;
            if (wr_ctrl) ctrl <= out_port[4:0];
        end
    end
endmodule
